// File: rtl/vga_tile_fetcher_pkg.sv
// Shared constants and types for the VGA tile fetcher.
// Holds the colour width, the VGA timing constants, the tile geometry and the
// fetch FSM state encoding.
package vga_tile_fetcher_pkg;

    localparam int unsigned COLOR_W      = 3;   // colour bits per tile
    localparam int unsigned TILES_X_LOG2 = 5;   // 32 tiles per row
    localparam int unsigned TILE_W_LOG2  = 5;   // 32-pixel-wide tiles
    localparam int unsigned TILE_H_LOG2  = 4;   // 16-pixel-high tiles
    localparam int unsigned TILES_X      = 1 << TILES_X_LOG2;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_TOTAL  = 525;

    localparam int unsigned CNT_W  = 10;                 // raster counter width
    localparam int unsigned ADDR_W = 2 * TILES_X_LOG2;   // {tile_row, tile_col}

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/vga_tile_fetcher_tile_line_buffer.sv
// Ping-pong tile line buffer: two banks of TILES_X colour entries.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset (clears both banks)
//   wr_en_i/wr_sel_i        write strobe and bank select (the back buffer)
//   wr_idx_i/wr_data_i      write tile index and colour
//   rd_sel_i/rd_idx_i       read bank (the active buffer) and tile index
//   rd_blank_i              force the registered read data to 0
//   rd_data_o               registered read data, one cycle after the index
module vga_tile_fetcher_tile_line_buffer
    import vga_tile_fetcher_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic                    wr_sel_i,
    input  logic [TILES_X_LOG2-1:0] wr_idx_i,
    input  logic [COLOR_W-1:0]      wr_data_i,
    input  logic                    rd_sel_i,
    input  logic [TILES_X_LOG2-1:0] rd_idx_i,
    input  logic                    rd_blank_i,
    output logic [COLOR_W-1:0]      rd_data_o
);

    logic [COLOR_W-1:0] mem_q [2][TILES_X];
    logic [COLOR_W-1:0] mem_d [2][TILES_X];
    logic [COLOR_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en_i) begin
            mem_d[wr_sel_i][wr_idx_i] = wr_data_i;
        end
        rd_data_d = rd_blank_i ? '0 : mem_q[rd_sel_i][rd_idx_i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(TILES_X); i++) begin
                    mem_q[b][i] <= '0;
                end
            end
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vga_tile_fetcher.sv
// VGA tile fetcher: prefetches one tile row of colours from video memory into
// a ping-pong line buffer during horizontal blanking, and drives the colour of
// the current pixel from the active buffer with one cycle of latency.
// Ports:
//   Clock, Reset               clock, asynchronous active-low reset
//   iEnable                    allows new fetches to start
//   iColumnCount, iRowCount    current raster position
//   oReadReq, oReadAddress     read request, address {tile_row, tile_col}
//   iReadAck, iReadData        read grant with valid colour in the same cycle
//   oPixel                     registered colour for the current pixel
//   oFetchBusy                 fetch FSM not idle
//   oUnderrun                  one-cycle pulse: swap point hit before fetch completed
// Build option: define SCANOUT_BLANK_EN to force oPixel to 0 outside the
// visible area; otherwise blanking is left to the VGA controller.
module vga_tile_fetcher
    import vga_tile_fetcher_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iEnable,
    input  logic [CNT_W-1:0]   iColumnCount,
    input  logic [CNT_W-1:0]   iRowCount,
    output logic               oReadReq,
    output logic [ADDR_W-1:0]  oReadAddress,
    input  logic               iReadAck,
    input  logic [COLOR_W-1:0] iReadData,
    output logic [COLOR_W-1:0] oPixel,
    output logic               oFetchBusy,
    output logic               oUnderrun
);

    fetch_state_e state_q, state_d;
    logic [TILES_X_LOG2-1:0] tile_row_q, tile_row_d;
    logic [TILES_X_LOG2-1:0] index_q, index_d;
    logic ready_q, ready_d;
    logic active_sel_q, active_sel_d;
    logic underrun_q, underrun_d;

    logic [CNT_W-1:0] nrow;
    logic trig_cond, trigger, swap_point, wr_en, blank;

    always_comb begin
        nrow = (iRowCount == CNT_W'(V_TOTAL - 1)) ? '0 : iRowCount + CNT_W'(1);
        // Fetch the next tile row at the start of H-blank of the row before it.
        trig_cond = (iColumnCount == CNT_W'(H_ACTIVE)) &&
                    (nrow[TILE_H_LOG2-1:0] == '0) &&
                    (nrow < CNT_W'(V_ACTIVE)) && iEnable;
        trigger = trig_cond && (state_q == StIdle);
        swap_point = (iColumnCount == '0) && (iRowCount[TILE_H_LOG2-1:0] == '0) &&
                     (iRowCount < CNT_W'(V_ACTIVE));
`ifdef SCANOUT_BLANK_EN
        blank = (iColumnCount >= CNT_W'(H_ACTIVE)) || (iRowCount >= CNT_W'(V_ACTIVE));
`else
        blank = 1'b0;
`endif
    end

    always_comb begin
        state_d      = state_q;
        tile_row_d   = tile_row_q;
        index_d      = index_q;
        ready_d      = ready_q;
        active_sel_d = active_sel_q;
        underrun_d   = 1'b0;
        wr_en        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d    = StReq;
                    tile_row_d = nrow[TILE_H_LOG2+TILES_X_LOG2-1:TILE_H_LOG2];
                    index_d    = '0;
                    ready_d    = 1'b0;
                end
            end
            StReq: begin
                if (iReadAck) begin
                    wr_en   = 1'b1;
                    index_d = index_q + 1'b1;
                    if (index_q == '1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // An incomplete fetch keeps running; the old row stays on screen.
        if (swap_point) begin
            if (ready_q) begin
                active_sel_d = ~active_sel_q;
                ready_d      = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= StIdle;
            tile_row_q   <= '0;
            index_q      <= '0;
            ready_q      <= 1'b0;
            active_sel_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tile_row_q   <= tile_row_d;
            index_q      <= index_d;
            ready_q      <= ready_d;
            active_sel_q <= active_sel_d;
            underrun_q   <= underrun_d;
        end
    end

    // Read with the post-swap select so column 0 of a new tile row already
    // shows the freshly fetched colours.
    vga_tile_fetcher_tile_line_buffer u_line_buffer (
        .clk_i      (Clock),
        .rst_ni     (Reset),
        .wr_en_i    (wr_en),
        .wr_sel_i   (~active_sel_q),
        .wr_idx_i   (index_q),
        .wr_data_i  (iReadData),
        .rd_sel_i   (active_sel_d),
        .rd_idx_i   (iColumnCount[CNT_W-1:TILE_W_LOG2]),
        .rd_blank_i (blank),
        .rd_data_o  (oPixel)
    );

    assign oReadReq     = (state_q == StReq);
    assign oReadAddress = {tile_row_q, index_q};
    assign oFetchBusy   = (state_q != StIdle);
    assign oUnderrun    = underrun_q;

    // H-blank is long enough that a new trigger never meets a busy fetcher.
    trigger_while_busy_a: assert property (@(posedge Clock) disable iff (!Reset)
        !(trig_cond && (state_q != StIdle)));

endmodule

// File: tb/tb_vga_tile_fetcher.sv
module tb_vga_tile_fetcher;
    import vga_tile_fetcher_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [9:0] col_i, row_i;
    logic       req;
    logic [9:0] addr;
    logic       ack;
    logic [2:0] rdata;
    logic [2:0] pixel;
    logic       busy;
    logic       underrun;

    always #5 clk = ~clk;

    vga_tile_fetcher dut (
        .Clock        (clk),
        .Reset        (rst_n),
        .iEnable      (en),
        .iColumnCount (col_i),
        .iRowCount    (row_i),
        .oReadReq     (req),
        .oReadAddress (addr),
        .iReadAck     (ack),
        .iReadData    (rdata),
        .oPixel       (pixel),
        .oFetchBusy   (busy),
        .oUnderrun    (underrun)
    );

    int n_vec = 0;
    int n_fail = 0;

    // Raster position and pending jump
    int col_r, row_r, next_col, next_row;
    bit jump;

    // Scoreboards: expected read addresses and expected pixels
    logic [9:0] exp_addr_q [$];
    logic [2:0] exp_pix_q [$];

    // Reference state
    int  shown_row;      // tile row on screen, -1 = cleared buffers
    int  pend_row;
    bit  pend_ready;
    bit  exp_un;

    // Memory responder
    int  ack_delay, wait_cnt, hold_cnt;
    bit  prev_stall;
    logic [9:0] prev_addr;
    int  ack_count, req_cycles, cyc, first_ack_cyc, last_ack_cyc;
    logic [9:0] first_ack_addr;

    // Memory contents: tile_row is added so different rows are distinguishable
    function automatic logic [2:0] memval(int tr, int tc);
        return 3'((tr + tc) % 8);
    endfunction

    task automatic model_reset();
        exp_addr_q.delete();
        exp_pix_q.delete();
        shown_row  = -1;
        pend_ready = 1'b0;
        exp_un     = 1'b0;
        prev_stall = 1'b0;
        wait_cnt   = 0;
        hold_cnt   = 0;
        ack        = 1'b0;
    endtask

    task automatic goto_pos(int r, int c);
        next_row = r;
        next_col = c;
        jump     = 1'b1;
    endtask

    // Drive the raster inputs for this cycle and push the expected results.
    task automatic drive_pos();
        int  nrow;
        bit  blank;
        col_i = 10'(col_r);
        row_i = 10'(row_r);
        nrow  = (row_r == 524) ? 0 : row_r + 1;
        if (col_r == 640 && nrow % 16 == 0 && nrow < 480 && en && exp_addr_q.size() == 0) begin
            for (int i = 0; i < 32; i++) exp_addr_q.push_back(10'((nrow / 16) * 32 + i));
            pend_ready = 1'b0;
            pend_row   = nrow / 16;
            ack_count  = 0;
        end
        exp_un = 1'b0;
        if (col_r == 0 && row_r % 16 == 0 && row_r < 480) begin
            if (pend_ready) begin
                shown_row  = pend_row;
                pend_ready = 1'b0;
            end else begin
                exp_un = 1'b1;
            end
        end
`ifdef SCANOUT_BLANK_EN
        blank = (col_r >= 640) || (row_r >= 480);
`else
        blank = 1'b0;
`endif
        exp_pix_q.push_back((blank || shown_row < 0) ? 3'd0 : memval(shown_row, (col_r / 32) % 32));
    endtask

    task automatic cycle();
        logic [2:0] px;
        logic [9:0] ea;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_pix_q.size() > 0) begin
            px = exp_pix_q.pop_front();
            n_vec++;
            if (pixel !== px) begin
                n_fail++;
                $display("FAIL pixel r%0d c%0d: got %0d expected %0d", row_r, col_r, pixel, px);
            end
        end
        n_vec++;
        if (underrun !== exp_un) begin
            n_fail++;
            $display("FAIL underrun r%0d c%0d: got %0b expected %0b", row_r, col_r, underrun, exp_un);
        end
        // Memory responder
        ack   = 1'b0;
        rdata = 3'($urandom);
        if (req) begin
            req_cycles++;
            if (exp_addr_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_req: got addr %0h expected no request", addr);
            end else begin
                if (prev_stall) begin
                    n_vec++;
                    if (addr !== prev_addr) begin
                        n_fail++;
                        $display("FAIL addr_stable: got %0h expected %0h", addr, prev_addr);
                    end
                end
                if (hold_cnt == 0 && wait_cnt >= ack_delay) begin
                    ack   = 1'b1;
                    rdata = memval(int'(addr[9:5]), int'(addr[4:0]));
                    ea    = exp_addr_q.pop_front();
                    n_vec++;
                    if (addr !== ea) begin
                        n_fail++;
                        $display("FAIL read_addr: got %0h expected %0h", addr, ea);
                    end
                    ack_count++;
                    if (ack_count == 1) begin
                        first_ack_cyc  = cyc;
                        first_ack_addr = addr;
                    end
                    if (exp_addr_q.size() == 0) begin
                        pend_ready   = 1'b1;
                        last_ack_cyc = cyc;
                    end
                    wait_cnt   = 0;
                    prev_stall = 1'b0;
                end else begin
                    wait_cnt++;
                    prev_stall = 1'b1;
                    prev_addr  = addr;
                end
            end
        end else begin
            ack        = 1'($urandom);   // stray acks must be ignored
            wait_cnt   = 0;
            prev_stall = 1'b0;
        end
        if (hold_cnt > 0) hold_cnt--;
        if (jump) begin
            col_r = next_col;
            row_r = next_row;
            jump  = 1'b0;
        end else begin
            col_r++;
            if (col_r == 800) begin
                col_r = 0;
                row_r = (row_r + 1) % 525;
            end
        end
        drive_pos();
    endtask

    task automatic run_to(int r, int c);
        int n = 0;
        while (!(row_r == r && col_r == c) && n < 5000) begin
            cycle();
            n++;
        end
        if (!(row_r == r && col_r == c)) begin
            n_vec++;
            n_fail++;
            $display("FAIL run_to_timeout: got r%0d c%0d expected r%0d c%0d", row_r, col_r, r, c);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        model_reset();
        col_r = 0;
        row_r = 500;
        col_i = 10'd0;
        row_i = 10'd500;
        rdata = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        n_vec += 5;
        if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b expected 0", req); end
        if (addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", addr); end
        if (pixel !== 3'd0) begin n_fail++; $display("FAIL reset_pixel: got %0d expected 0", pixel); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_underrun: got %0b expected 0", underrun);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_first_row();
        en        = 1'b1;
        ack_delay = 0;
        goto_pos(524, 630);
        cycle();
        req_cycles = 0;
        run_to(0, 5);
        n_vec += 2;
        if (req_cycles != 32) begin
            n_fail++;
            $display("FAIL first_req_cycles: got %0d expected 32", req_cycles);
        end
        if (last_ack_cyc - first_ack_cyc != 31) begin
            n_fail++;
            $display("FAIL first_back_to_back: got span %0d expected 31", last_ack_cyc - first_ack_cyc);
        end
        goto_pos(0, 95);
        cycle();
        run_to(0, 100);
        cycle();
        n_vec++;
        if (pixel !== 3'd3) begin
            n_fail++;
            $display("FAIL first_pixel_c100: got %0d expected 3", pixel);
        end
    endtask

    task automatic test_underrun();
        goto_pos(15, 630);
        cycle();
        hold_cnt = 210;
        run_to(16, 0);
        cycle();
        n_vec++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_pulse: got %0b expected 1", underrun);
        end
        run_to(16, 700);
        goto_pos(31, 630);
        cycle();
        run_to(32, 660);
    endtask

    task automatic test_ack_delay();
        ack_delay = 2;
        goto_pos(47, 630);
        cycle();
        run_to(48, 665);
        ack_delay = 0;
    endtask

    task automatic test_reset_mid_fetch();
        int n = 0;
        ack_delay = 1;
        goto_pos(63, 630);
        cycle();
        while (!(ack_count == 10 && exp_addr_q.size() == 22) && n < 400) begin
            cycle();
            n++;
        end
        if (n >= 400) begin
            n_vec++;
            n_fail++;
            $display("FAIL mid_fetch_timeout: got %0d acks expected 10", ack_count);
        end
        cycle();   // clocks the 10th read, index is now 10
        #2 rst_n = 1'b0;
        #1;
        n_vec += 3;
        if (req !== 1'b0) begin n_fail++; $display("FAIL midreset_req: got %0b expected 0", req); end
        if (pixel !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_pixel: got %0d expected 0", pixel);
        end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %0b expected 0", busy); end
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        ack_delay = 0;
        goto_pos(79, 630);
        cycle();
        run_to(80, 100);
        n_vec++;
        if (first_ack_addr !== 10'(5 * 32)) begin
            n_fail++;
            $display("FAIL restart_index0: got %0h expected %0h", first_ack_addr, 10'(5 * 32));
        end
    endtask

    task automatic test_enable();
        en = 1'b0;
        goto_pos(95, 630);
        cycle();
        req_cycles = 0;
        run_to(96, 40);
        n_vec++;
        if (req_cycles != 0) begin
            n_fail++;
            $display("FAIL disabled_req: got %0d req cycles expected 0", req_cycles);
        end
        en = 1'b1;
        goto_pos(111, 630);
        cycle();
        run_to(112, 40);
    endtask

    task automatic test_blank();
        logic [2:0] exp;
        goto_pos(112, 690);
        cycle();
        run_to(112, 700);
        cycle();
`ifdef SCANOUT_BLANK_EN
        exp = 3'd0;
`else
        exp = memval(7, 21);
`endif
        n_vec++;
        if (pixel !== exp) begin
            n_fail++;
            $display("FAIL col700_pixel: got %0d expected %0d", pixel, exp);
        end
    endtask

    initial begin
        cyc  = 0;
        jump = 1'b0;
        ack_count = 0;
        test_reset();
        test_first_row();
        test_underrun();
        test_ack_delay();
        test_reset_mid_fetch();
        test_enable();
        test_blank();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
